// File: rtl/rc4_decrypt_core.sv
// RC4 decryption engine: S-box init, key scheduling and keystream XOR over
// external synchronous-read S RAM, message ROM and result RAM.
module rc4_decrypt_core #(
  parameter int KEY_BYTES = 3,
  parameter int MSG_LEN   = 32,
  parameter int AW        = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wdata,
  output logic                   s_wren,
  input  logic [7:0]             s_rdata,
  output logic [AW-1:0]          encrypted_mes_adr,
  input  logic [7:0]             encrypted_mes_data,
  output logic [AW-1:0]          decrypted_adr,
  output logic [7:0]             decrypted_data,
  output logic                   dmr_trigger
);

  localparam int             KIW     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIW-1:0] KI_LAST = KIW'(KEY_BYTES - 1);
  localparam logic [AW-1:0]  K_LAST  = AW'(MSG_LEN - 1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_INIT   = 4'd1;
  localparam logic [3:0] S_KSA_RD = 4'd2;
  localparam logic [3:0] S_KSA_GI = 4'd3;
  localparam logic [3:0] S_KSA_WI = 4'd4;
  localparam logic [3:0] S_KSA_WJ = 4'd5;
  localparam logic [3:0] S_P_RD   = 4'd6;
  localparam logic [3:0] S_P_GI   = 4'd7;
  localparam logic [3:0] S_P_GJ   = 4'd8;
  localparam logic [3:0] S_P_WI   = 4'd9;
  localparam logic [3:0] S_P_WJ   = 4'd10;
  localparam logic [3:0] S_P_RF   = 4'd11;
  localparam logic [3:0] S_P_OUT  = 4'd12;
  localparam logic [3:0] S_DONE   = 4'd13;

  logic [3:0]     state;
  logic [7:0]     i, j, si, sj;
  logic [AW-1:0]  k;
  logic [KIW-1:0] kidx;   // tracks i mod KEY_BYTES without a divider
  logic [7:0]     key_byte;
  logic [7:0]     j_ksa, j_prga;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kidx == KIW'(b)) key_byte = secret_key[8*(KEY_BYTES-1-b) +: 8];
    end
  end

  assign j_ksa  = j + s_rdata + key_byte;
  assign j_prga = j + s_rdata;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      kidx  <= '0;
      si    <= '0;
      sj    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_INIT;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            kidx  <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        S_INIT: begin
          i <= i + 8'd1;
          if (i == 8'hFF) begin
            state <= S_KSA_RD;
            j     <= '0;
            kidx  <= '0;
          end
        end
        S_KSA_RD: state <= S_KSA_GI;
        S_KSA_GI: begin
          si    <= s_rdata;
          j     <= j_ksa;
          state <= S_KSA_WI;
        end
        // S[j] arrives here and is written straight back to S[i]; the single
        // S RAM port cannot overlap the S[j] write with the next S[i] read.
        S_KSA_WI: begin
          sj    <= s_rdata;
          state <= S_KSA_WJ;
        end
        S_KSA_WJ: begin
          kidx <= (kidx == KI_LAST) ? '0 : kidx + 1'b1;
          if (i == 8'hFF) begin
            i     <= 8'd1;
            j     <= '0;
            k     <= '0;
            state <= S_P_RD;
          end else begin
            i     <= i + 8'd1;
            state <= S_KSA_RD;
          end
        end
        S_P_RD: state <= S_P_GI;
        S_P_GI: begin
          si    <= s_rdata;
          j     <= j_prga;
          state <= S_P_GJ;
        end
        S_P_GJ: begin
          sj    <= s_rdata;
          state <= S_P_WI;
        end
        S_P_WI: state <= S_P_WJ;
        S_P_WJ: state <= S_P_RF;
        S_P_RF: state <= S_P_OUT;
        S_P_OUT: begin
          i <= i + 8'd1;
          k <= k + 1'b1;
          if (k == K_LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= S_P_RD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory strobes decode from state only; s_rdata feeds data and address, never an enable.
  always_comb begin
    s_addr            = '0;
    s_wdata           = '0;
    s_wren            = 1'b0;
    encrypted_mes_adr = '0;
    decrypted_adr     = '0;
    decrypted_data    = '0;
    dmr_trigger       = 1'b0;
    case (state)
      S_INIT: begin
        s_addr  = i;
        s_wdata = i;
        s_wren  = 1'b1;
      end
      S_KSA_RD, S_P_RD: s_addr = i;
      S_KSA_GI:         s_addr = j_ksa;
      S_P_GI:           s_addr = j_prga;
      S_KSA_WI: begin
        s_addr  = i;
        s_wdata = s_rdata;
        s_wren  = 1'b1;
      end
      S_P_WI: begin
        s_addr  = i;
        s_wdata = sj;
        s_wren  = 1'b1;
      end
      S_KSA_WJ, S_P_WJ: begin
        s_addr  = j;
        s_wdata = si;
        s_wren  = 1'b1;
      end
      S_P_RF: begin
        s_addr            = si + sj;
        encrypted_mes_adr = k;
      end
      S_P_OUT: begin
        decrypted_adr  = k;
        decrypted_data = s_rdata ^ encrypted_mes_data;
        dmr_trigger    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// Self-checking bench for rc4_decrypt_core: two instances (3-byte key / 9-byte
// message and 4-byte key / 5-byte message) against a plain RC4 reference model.
module tb_rc4_decrypt_core;

  localparam int N_A   = 9;
  localparam int N_B   = 5;
  localparam int AW_A  = 4;
  localparam int AW_B  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, start_a, start_b;
  logic [23:0] key_a;
  logic [31:0] key_b;

  logic busy_a, done_a, s_wren_a, dmr_a;
  logic [7:0] s_addr_a, s_wdata_a, s_rdata_a, enc_data_a, dec_data_a;
  logic [AW_A-1:0] enc_adr_a, dec_adr_a;

  logic busy_b, done_b, s_wren_b, dmr_b;
  logic [7:0] s_addr_b, s_wdata_b, s_rdata_b, enc_data_b, dec_data_b;
  logic [AW_B-1:0] enc_adr_b, dec_adr_b;

  rc4_decrypt_core #(.KEY_BYTES(3), .MSG_LEN(N_A), .AW(AW_A)) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .secret_key(key_a),
    .busy(busy_a), .done(done_a),
    .s_addr(s_addr_a), .s_wdata(s_wdata_a), .s_wren(s_wren_a), .s_rdata(s_rdata_a),
    .encrypted_mes_adr(enc_adr_a), .encrypted_mes_data(enc_data_a),
    .decrypted_adr(dec_adr_a), .decrypted_data(dec_data_a), .dmr_trigger(dmr_a)
  );

  rc4_decrypt_core #(.KEY_BYTES(4), .MSG_LEN(N_B), .AW(AW_B)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .secret_key(key_b),
    .busy(busy_b), .done(done_b),
    .s_addr(s_addr_b), .s_wdata(s_wdata_b), .s_wren(s_wren_b), .s_rdata(s_rdata_b),
    .encrypted_mes_adr(enc_adr_b), .encrypted_mes_data(enc_data_b),
    .decrypted_adr(dec_adr_b), .decrypted_data(dec_data_b), .dmr_trigger(dmr_b)
  );

  // Synchronous-read memories, one cycle of latency.
  logic [7:0] sram_a[256], rom_a[16], res_a[16];
  logic [7:0] sram_b[256], rom_b[8],  res_b[8];

  always @(posedge clk) begin
    if (s_wren_a) sram_a[s_addr_a] <= s_wdata_a;
    else          s_rdata_a <= sram_a[s_addr_a];
    enc_data_a <= rom_a[enc_adr_a];
    if (dmr_a) res_a[dec_adr_a] <= dec_data_a;
  end

  always @(posedge clk) begin
    if (s_wren_b) sram_b[s_addr_b] <= s_wdata_b;
    else          s_rdata_b <= sram_b[s_addr_b];
    enc_data_b <= rom_b[enc_adr_b];
    if (dmr_b) res_b[dec_adr_b] <= dec_data_b;
  end

  logic [7:0] ct_key[9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] pt_key[9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] ct_wiki[5] = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
  logic [7:0] pt_wiki[5] = '{8'h70, 8'h65, 8'h64, 8'h69, 8'h61};

  int n_cmp, n_bad;
  int tidx_a, tidx_b;
  logic [7:0] exp_a[16], exp_b[8];
  logic [7:0] mdl_s[256], mdl_ks[256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Textbook RC4: S after key scheduling into mdl_s, first n keystream bytes into mdl_ks.
  task automatic model_run(input logic [255:0] key, input int kb, input int n);
    logic [7:0] s[256];
    logic [7:0] t;
    int jj, ii;
    for (int x = 0; x < 256; x++) s[x] = 8'(x);
    jj = 0;
    for (int x = 0; x < 256; x++) begin
      jj = (jj + int'(s[x]) + int'(key[8*(kb-1-(x % kb)) +: 8])) % 256;
      t = s[x]; s[x] = s[jj]; s[jj] = t;
    end
    mdl_s = s;
    ii = 0;
    jj = 0;
    for (int x = 0; x < n; x++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(s[ii])) % 256;
      t = s[ii]; s[ii] = s[jj]; s[jj] = t;
      mdl_ks[x] = s[(int'(s[ii]) + int'(s[jj])) % 256];
    end
  endtask

  // One clock; afterwards every result-RAM write is compared with the model.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (dmr_a === 1'b1) begin
      check("a_trig_adr", 32'(dec_adr_a), 32'(tidx_a));
      check("a_trig_data", 32'(dec_data_a), (tidx_a < N_A) ? 32'(exp_a[tidx_a]) : 32'hDEAD);
      tidx_a++;
    end
    if (dmr_b === 1'b1) begin
      check("b_trig_adr", 32'(dec_adr_b), 32'(tidx_b));
      check("b_trig_data", 32'(dec_data_b), (tidx_b < N_B) ? 32'(exp_b[tidx_b]) : 32'hDEAD);
      tidx_b++;
    end
  endtask

  // mode 0: plain run, 1: extra start pulses at cycles 10/700,
  // 2: reset at cycle 1300, 3: S-box check at cycle 1281.
  task automatic run(input int inst, input logic [31:0] key, input int mode);
    int n, tot;
    logic bsy, dn;
    n   = (inst == 0) ? N_A : N_B;
    tot = 1280 + 7 * n;
    if (inst == 0) begin
      key_a = key[23:0];
      model_run({232'd0, key[23:0]}, 3, N_A);
      for (int x = 0; x < N_A; x++) exp_a[x] = mdl_ks[x] ^ rom_a[x];
      tidx_a  = 0;
      start_a = 1'b1;
    end else begin
      key_b = key;
      model_run({224'd0, key}, 4, N_B);
      for (int x = 0; x < N_B; x++) exp_b[x] = mdl_ks[x] ^ rom_b[x];
      tidx_b  = 0;
      start_b = 1'b1;
    end
    cycle();
    start_a = 1'b0;
    start_b = 1'b0;
    for (int lat = 1; lat <= tot + 2; lat++) begin
      if (mode == 1 && (lat == 10 || lat == 700)) begin
        if (inst == 0) start_a = 1'b1;
        else           start_b = 1'b1;
      end
      if (mode == 2 && lat == 1300) rst_a = 1'b1;
      cycle();
      start_a = 1'b0;
      start_b = 1'b0;
      rst_a   = 1'b0;
      if (mode == 2 && lat == 1300) begin
        check("mid_reset_ctl", 32'({busy_a, done_a, s_wren_a, dmr_a}), 32'd0);
        check("mid_reset_bus", {s_addr_a, s_wdata_a, dec_data_a, enc_adr_a, dec_adr_a}, 32'd0);
        return;
      end
      if (mode == 3 && lat == 1281) begin
        for (int x = 0; x < 256; x++)
          check($sformatf("sbox[%0d]", x), 32'(sram_a[x]), 32'(mdl_s[x]));
      end
      bsy = (inst == 0) ? busy_a : busy_b;
      dn  = (inst == 0) ? done_a : done_b;
      check($sformatf("busy@%0d", lat), 32'(bsy), 32'(lat < tot));
      check($sformatf("done@%0d", lat), 32'(dn), 32'(lat >= tot));
    end
    check("trigger_count", 32'((inst == 0) ? tidx_a : tidx_b), 32'(n));
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    tidx_a  = N_A;
    tidx_b  = N_B;
    rst_a   = 1'b1;
    rst_b   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    key_a   = '0;
    key_b   = '0;
    repeat (2) cycle();
    check("reset_ctl_a", 32'({busy_a, done_a, s_wren_a, dmr_a}), 32'd0);
    check("reset_bus_a", {s_addr_a, s_wdata_a, dec_data_a, enc_adr_a, dec_adr_a}, 32'd0);
    check("reset_ctl_b", 32'({busy_b, done_b, s_wren_b, dmr_b}), 32'd0);
    check("reset_bus_b", {s_addr_b, s_wdata_b, dec_data_b, 2'b00, enc_adr_b, dec_adr_b}, 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    cycle();

    // "Key" -> "Plaintext", then twice more from DONE (second with stray starts).
    for (int x = 0; x < N_A; x++) rom_a[x] = ct_key[x];
    for (int r = 0; r < 3; r++) begin
      run(0, 32'h004B6579, (r == 2) ? 1 : 0);
      for (int x = 0; x < N_A; x++) begin
        if (r == 0) check($sformatf("model_key[%0d]", x), 32'(exp_a[x]), 32'(pt_key[x]));
        check($sformatf("key_run%0d[%0d]", r, x), 32'(res_a[x]), 32'(pt_key[x]));
      end
    end

    // "Wiki" -> "pedia" on the 4-byte-key instance.
    for (int x = 0; x < N_B; x++) rom_b[x] = ct_wiki[x];
    run(1, 32'h57696B69, 0);
    for (int x = 0; x < N_B; x++) begin
      check($sformatf("model_wiki[%0d]", x), 32'(exp_b[x]), 32'(pt_wiki[x]));
      check($sformatf("wiki[%0d]", x), 32'(res_b[x]), 32'(pt_wiki[x]));
    end

    // Random keys and ciphertexts.
    for (int r = 0; r < 3; r++) begin
      for (int x = 0; x < N_A; x++) rom_a[x] = 8'($urandom);
      run(0, 32'($urandom) & 32'h00FF_FFFF, 0);
      for (int x = 0; x < N_A; x++) check($sformatf("rand_a%0d[%0d]", r, x), 32'(res_a[x]), 32'(exp_a[x]));
      for (int x = 0; x < N_B; x++) rom_b[x] = 8'($urandom);
      run(1, 32'($urandom), 0);
      for (int x = 0; x < N_B; x++) check($sformatf("rand_b%0d[%0d]", r, x), 32'(res_b[x]), 32'(exp_b[x]));
    end

    // S-box state right after key scheduling with an all-zero key.
    run(0, 32'd0, 3);

    // Reset during PRGA, then a complete fresh run.
    for (int x = 0; x < N_A; x++) rom_a[x] = 8'($urandom);
    run(0, 32'($urandom) & 32'h00FF_FFFF, 2);
    cycle();
    run(0, 32'($urandom) & 32'h00FF_FFFF, 0);
    for (int x = 0; x < N_A; x++) check($sformatf("after_reset[%0d]", x), 32'(res_a[x]), 32'(exp_a[x]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
